// File: rtl/rst_seq_ctrl_if.sv
// Status/control bundle of the reset sequencer: lock and soft-reset in, staged resets and status out.
// The slave modport is the sequencer; the master modport is whoever drives lock/soft-reset and reads status.
interface rst_seq_ctrl_if #(
  parameter int NUM_STAGES = 3
);
  logic                  pll_locked_i;
  logic                  soft_rst_i;
  logic [NUM_STAGES-1:0] rst_n_o;
  logic                  rst_done_o;
  logic [1:0]            state_o;

  modport master (
    output pll_locked_i, soft_rst_i,
    input  rst_n_o, rst_done_o, state_o
  );

  modport slave (
    input  pll_locked_i, soft_rst_i,
    output rst_n_o, rst_done_o, state_o
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: waits for stable PLL lock, then releases stage resets in order with a fixed gap.
// Lock rise to stage 0: 2 sync + LOCK_STABLE_CYC edges; abort (lock loss/soft reset) clears all; no backpressure.
module rst_seq_ctrl #(
  parameter int NUM_STAGES      = 3,
  parameter int LOCK_STABLE_CYC = 1024,
  parameter int STAGE_GAP_CYC   = 16,
  parameter int CNT_W           = 16
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  rst_seq_ctrl_if.slave bus
);

  localparam int IDX_W   = $clog2(NUM_STAGES + 1);
  localparam int MAX_CNT = ((LOCK_STABLE_CYC > STAGE_GAP_CYC) ? LOCK_STABLE_CYC : STAGE_GAP_CYC) - 1;

  if (NUM_STAGES < 1) begin : g_err_stages
    $error("rst_seq_ctrl: NUM_STAGES must be >= 1");
  end
  if (LOCK_STABLE_CYC < 1) begin : g_err_lock
    $error("rst_seq_ctrl: LOCK_STABLE_CYC must be >= 1");
  end
  if (STAGE_GAP_CYC < 1) begin : g_err_gap
    $error("rst_seq_ctrl: STAGE_GAP_CYC must be >= 1");
  end
  if ((CNT_W < 1) || ((CNT_W < 31) && (MAX_CNT >= (1 << CNT_W)))) begin : g_err_cnt
    $error("rst_seq_ctrl: CNT_W too small for the programmed counts");
  end

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_RELEASE   = 2'd1,
    S_DONE      = 2'd2
  } state_t;

  logic                  r_lock_meta;
  logic                  r_lock_s;
  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [NUM_STAGES-1:0] r_rst_n;
  logic                  r_done;

  logic                  w_abort;
  logic [NUM_STAGES-1:0] w_rel_next;

  assign w_abort    = !r_lock_s || bus.soft_rst_i;
  // Releases are strictly in order, so releasing the next stage is a shift-in of a 1.
  assign w_rel_next = NUM_STAGES'({r_rst_n, 1'b1});

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
      r_state     <= S_WAIT_LOCK;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_rst_n     <= '0;
      r_done      <= 1'b0;
    end else begin
      r_lock_meta <= bus.pll_locked_i;
      r_lock_s    <= r_lock_meta;
      if (w_abort) begin
        r_state <= S_WAIT_LOCK;
        r_cnt   <= '0;
        r_idx   <= '0;
        r_rst_n <= '0;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          S_WAIT_LOCK: begin
            if (r_cnt == CNT_W'(LOCK_STABLE_CYC - 1)) begin
              r_rst_n <= w_rel_next;
              r_cnt   <= '0;
              r_idx   <= IDX_W'(1);
              if (NUM_STAGES == 1) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_state <= S_RELEASE;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_RELEASE: begin
            if (r_cnt == CNT_W'(STAGE_GAP_CYC - 1)) begin
              r_rst_n <= w_rel_next;
              r_cnt   <= '0;
              r_idx   <= r_idx + 1'b1;
              if (r_idx == IDX_W'(NUM_STAGES - 1)) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_DONE: begin
            r_cnt <= '0;
          end
          default: begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rst_n <= '0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rst_n_o    = r_rst_n;
  assign bus.rst_done_o = r_done;
  assign bus.state_o    = r_state;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: directed scenarios with literal latencies, then random lock/soft/reset traffic
// checked every cycle against a run-length model of the release schedule.
module tb_rst_seq_ctrl;
  localparam int N = 3;
  localparam int L = 8;
  localparam int G = 4;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  rst_seq_ctrl_if #(.NUM_STAGES(N)) u_if ();

  rst_seq_ctrl #(
    .NUM_STAGES     (N),
    .LOCK_STABLE_CYC(L),
    .STAGE_GAP_CYC  (G),
    .CNT_W          (8)
  ) dut (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .bus    (u_if)
  );

  int total = 0;
  int bad   = 0;

  // Model: m_run = consecutive edges without an abort (lock seen low after 2-flop sync, or soft reset).
  int m_run;
  bit m_s1, m_s2;
  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_run = 0;
      m_s1  = 1'b0;
      m_s2  = 1'b0;
    end else begin
      if (!m_s2 || u_if.soft_rst_i) m_run = 0;
      else m_run = m_run + 1;
      m_s2 = m_s1;
      m_s1 = u_if.pll_locked_i;
    end
  end

  function automatic int stages_released(input int run);
    int r;
    if (run < L) return 0;
    r = 1 + (run - L) / G;
    return (r > N) ? N : r;
  endfunction

  always @(negedge clk_i) begin
    int       rel;
    logic [2:0] e_rst;
    logic [1:0] e_st;
    logic       e_done;
    rel    = stages_released(m_run);
    e_rst  = 3'((1 << rel) - 1);
    e_done = (rel == N);
    e_st   = (rel == 0) ? 2'd0 : ((rel == N) ? 2'd2 : 2'd1);
    total++;
    if (u_if.rst_n_o !== e_rst || u_if.rst_done_o !== e_done || u_if.state_o !== e_st) begin
      bad++;
      $display("FAIL model t=%0t rst_n_o=%b want %b done=%b want %b state=%0d want %0d",
               $time, u_if.rst_n_o, e_rst, u_if.rst_done_o, e_done, u_if.state_o, e_st);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Edges from now until rst_n_o shows tgt; -1 if it never does.
  task automatic edges_until(input logic [2:0] tgt, output int n);
    n = 0;
    forever begin
      @(posedge clk_i);
      n++;
      @(negedge clk_i);
      if (u_if.rst_n_o === tgt) break;
      if (n >= 200) begin
        n = -1;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int len;
    u_if.pll_locked_i = 1'b0;
    u_if.soft_rst_i   = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("reset rst_n_o", int'(u_if.rst_n_o), 0);
    chk("reset state", int'(u_if.state_o), 0);
    rst_n_i = 1'b1;

    repeat (50) @(negedge clk_i);
    chk("no lock rst_n_o", int'(u_if.rst_n_o), 0);
    chk("no lock done", int'(u_if.rst_done_o), 0);

    u_if.pll_locked_i = 1'b1;
    edges_until(3'b001, n); chk("lock to stage0", n, 10);
    edges_until(3'b011, n); chk("stage0 to stage1", n, 4);
    edges_until(3'b111, n); chk("stage1 to stage2", n, 4);
    chk("done after all", int'(u_if.rst_done_o), 1);
    chk("state done", int'(u_if.state_o), 2);

    u_if.pll_locked_i = 1'b0;
    repeat (6) @(negedge clk_i);
    u_if.pll_locked_i = 1'b1;
    repeat (6) @(negedge clk_i);
    u_if.pll_locked_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("glitch no release", int'(u_if.rst_n_o), 0);
    u_if.pll_locked_i = 1'b1;
    edges_until(3'b001, n); chk("relock after glitch", n, 10);

    edges_until(3'b011, n); chk("gap before loss", n, 4);
    u_if.pll_locked_i = 1'b0;
    edges_until(3'b000, n); chk("lock loss latency", n, 3);
    u_if.pll_locked_i = 1'b1;
    edges_until(3'b001, n); chk("restart stage0", n, 10);

    edges_until(3'b111, n); chk("reach done", n, 8);
    u_if.soft_rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("soft rst_n_o", int'(u_if.rst_n_o), 0);
    chk("soft done", int'(u_if.rst_done_o), 0);
    u_if.soft_rst_i = 1'b0;
    edges_until(3'b001, n); chk("after soft", n, 8);

    edges_until(3'b011, n); chk("mid release", n, 4);
    #2 rst_n_i = 1'b0;
    #1;
    chk("async rst_n_o", int'(u_if.rst_n_o), 0);
    chk("async state", int'(u_if.state_o), 0);
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    edges_until(3'b001, n); chk("after hard reset", n, 10);
    edges_until(3'b111, n); chk("full after hard reset", n, 8);

    repeat (150) begin
      u_if.pll_locked_i = ($urandom_range(0, 3) != 0);
      u_if.soft_rst_i   = ($urandom_range(0, 9) == 0);
      len = $urandom_range(1, 25);
      @(negedge clk_i);
      u_if.soft_rst_i = 1'b0;
      repeat (len) @(negedge clk_i);
      if ($urandom_range(0, 19) == 0) begin
        #2 rst_n_i = 1'b0;
        @(negedge clk_i);
        #2 rst_n_i = 1'b1;
      end
    end

    @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
